cpu_pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage CPU (IF/ID/EX/MEM/WB). Generates the
//  per-boundary pipe_en strobes consumed by every pipeline register, plus flush
//  (bubble-insert) strobes that zero the stage's pipe_in mux. Resolves load-use

---
 rtl/cpu_pipe_ctrl_pkg.sv | 45 ++++
 rtl/cpu_pipe_ctrl_if.sv | 52 +++++
 rtl/cpu_pipe_ctrl_hazard.sv | 34 +++
 rtl/cpu_pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cpu_pipe_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_pkg
// Description : Shared types and constants for the 5-stage pipeline
//               controller: controller state enumeration and the packed
//               enable/flush control word with its canonical patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

  // Controller states
  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MUL_WAIT = 2'd2,
    MEM_WAIT = 2'd3
  } pipe_state_t;

  // One control word drives every pipeline-register strobe at once
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctl_t;

  //                                         pc ifid idex exmem memwb | fIF fID fEX
  localparam pipe_ctl_t PIPE_FREEZE  = 8'b0_0_0_0_0_0_0_0;
  localparam pipe_ctl_t PIPE_RUN     = 8'b1_1_1_1_1_0_0_0;
  localparam pipe_ctl_t PIPE_CLEAR   = 8'b0_1_1_1_1_1_1_1;
  // Taken branch: two bubbles replace the wrong-path IF and ID instructions
  localparam pipe_ctl_t PIPE_BRANCH  = 8'b1_1_1_1_1_1_1_0;
  // Multiply holds IF/ID/EX; a bubble drains into MEM each cycle
  localparam pipe_ctl_t PIPE_MUL     = 8'b0_0_0_1_1_0_0_1;
  // Load-use: hold PC and IF/ID, bubble into EX
  localparam pipe_ctl_t PIPE_LDUSE   = 8'b0_0_1_1_1_0_1_0;
  // Memory timeout: aborted access is replaced by a bubble and the pipe resumes
  localparam pipe_ctl_t PIPE_TIMEOUT = 8'b1_1_1_1_1_0_0_1;

endpackage
`default_nettype wire

// File: rtl/cpu_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_ctrl_if
// Description : Bundle between the pipeline datapath and its controller.
//               Hazard status flows datapath -> controller; enable and flush
//               strobes flow controller -> datapath.
//   master : controller side (reads status, drives strobes)
//   slave  : datapath side   (drives status, reads strobes)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_pipe_ctrl_if #(
  parameter int REG_AW = 5
);
  // Status from the datapath
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_br_taken;
  logic              ex_mul_start;
  logic              mem_req;
  logic              mem_ack;
  // Strobes to the datapath
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              mem_err;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_is_load, ex_rd, ex_br_taken, ex_mul_start,
    input  mem_req, mem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, mem_err
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_is_load, ex_rd, ex_br_taken, ex_mul_start,
    output mem_req, mem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/cpu_pipe_ctrl_hazard.sv
`default_nettype none
// ============================================================================
// Module      : cpu_hazard_detect
// Description : Combinational load-use hazard compare. Flags when the EX
//               instruction is a load whose destination is read by the ID
//               instruction. x0 is hard-wired zero, so it never hazards.
// Ports       : ex_is_load, ex_rd          - EX load and its destination
//               id_rs1/2, id_use_rs1/2     - ID sources and their use flags
//               load_use                   - hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_hazard_detect #(
  parameter int REG_AW = 5
) (
  input  wire logic              ex_is_load,
  input  wire logic [REG_AW-1:0] ex_rd,
  input  wire logic [REG_AW-1:0] id_rs1,
  input  wire logic [REG_AW-1:0] id_rs2,
  input  wire logic              id_use_rs1,
  input  wire logic              id_use_rs2,
  output logic                   load_use
);

  logic w_rd_nonzero;
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_rd_nonzero = (ex_rd != '0);
  assign w_hit_rs1    = id_use_rs1 & (id_rs1 == ex_rd);
  assign w_hit_rs2    = id_use_rs2 & (id_rs2 == ex_rd);
  assign load_use     = ex_is_load & w_rd_nonzero & (w_hit_rs1 | w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/cpu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_ctrl
// Description : Central controller for the 5-stage pipeline. Produces the
//               per-boundary enable strobes and bubble-insert flushes from
//               load-use, taken-branch, multi-cycle multiply and data-memory
//               wait conditions. Strobes are combinational from state+status.
// Ports       : clk, rst_n (async, active-low)
//               bus (master) - hazard status in, strobes and mem_err out
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 256
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  cpu_pipe_ctrl_if.master bus
);

  localparam int MUL_CW = $clog2(MUL_LAT);
  localparam int MEM_CW = $clog2(MEM_TIMEOUT + 1);

  // The first EX cycle of a multiply is spent in RUN and the last one is the
  // cycle after MUL_WAIT, so MUL_WAIT itself lasts MUL_LAT-2 cycles.
  localparam logic [MUL_CW-1:0] c_mul_load = MUL_CW'(MUL_LAT - 2);
  localparam logic [MEM_CW-1:0] c_mem_last = MEM_CW'(MEM_TIMEOUT - 1);
  localparam logic [MUL_CW-1:0] c_mul_one  = MUL_CW'(1);
  localparam logic [MEM_CW-1:0] c_mem_one  = MEM_CW'(1);

  pipe_state_t       r_state,     w_state_nxt;
  logic [MUL_CW-1:0] r_mul_cnt,   w_mul_cnt_nxt;
  logic [MEM_CW-1:0] r_mem_cnt,   w_mem_cnt_nxt;
  logic              r_ret_mul,   w_ret_mul_nxt;
  pipe_ctl_t         w_ctl;
  logic              w_mem_err;
  logic              w_load_use;
  logic              w_mem_stall;

  cpu_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .load_use   (w_load_use)
  );

  // An access acknowledged in the same cycle it is requested never stalls
  assign w_mem_stall = bus.mem_req & ~bus.mem_ack;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT;
      r_mul_cnt <= '0;
      r_mem_cnt <= '0;
      r_ret_mul <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      r_mem_cnt <= w_mem_cnt_nxt;
      r_ret_mul <= w_ret_mul_nxt;
    end
  end

  // ------------------------------------------------- next state and strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    w_mem_cnt_nxt = r_mem_cnt;
    w_ret_mul_nxt = r_ret_mul;
    w_ctl         = PIPE_RUN;
    w_mem_err     = 1'b0;

    unique case (r_state)
      INIT: begin
        w_ctl       = PIPE_CLEAR;
        w_state_nxt = RUN;
      end

      RUN: begin
        if (w_mem_stall) begin
          w_ctl         = PIPE_FREEZE;
          w_state_nxt   = MEM_WAIT;
          w_mem_cnt_nxt = '0;
          w_ret_mul_nxt = 1'b0;
        end else if (bus.ex_br_taken) begin
          // Branch beats load-use: the ID instruction is squashed regardless
          w_ctl = PIPE_BRANCH;
        end else if (bus.ex_mul_start) begin
          w_ctl         = PIPE_MUL;
          w_mul_cnt_nxt = c_mul_load;
          w_state_nxt   = (MUL_LAT > 2) ? MUL_WAIT : RUN;
        end else if (w_load_use) begin
          w_ctl = PIPE_LDUSE;
        end
      end

      MUL_WAIT: begin
        if (w_mem_stall) begin
          // The multiply's progress is held while memory is outstanding
          w_ctl         = PIPE_FREEZE;
          w_state_nxt   = MEM_WAIT;
          w_mem_cnt_nxt = '0;
          w_ret_mul_nxt = 1'b1;
        end else begin
          w_ctl = PIPE_MUL;
          if (r_mul_cnt <= c_mul_one) begin
            w_state_nxt = RUN;
          end
          if (r_mul_cnt != '0) begin
            w_mul_cnt_nxt = r_mul_cnt - c_mul_one;
          end
        end
      end

      MEM_WAIT: begin
        if (bus.mem_ack) begin
          w_ret_mul_nxt = 1'b0;
          if (r_ret_mul) begin
            // The MEM result is still captured (exmem/memwb enabled) but the
            // multiply in EX must not be advanced, so the ack cycle uses the
            // multiply pattern and counts as one of its wait cycles.
            w_ctl       = PIPE_MUL;
            w_state_nxt = (r_mul_cnt <= c_mul_one) ? RUN : MUL_WAIT;
            if (r_mul_cnt != '0) begin
              w_mul_cnt_nxt = r_mul_cnt - c_mul_one;
            end
          end else begin
            w_ctl       = PIPE_RUN;
            w_state_nxt = RUN;
          end
        end else if (r_mem_cnt == c_mem_last) begin
          w_ctl         = PIPE_TIMEOUT;
          w_mem_err     = 1'b1;
          w_state_nxt   = RUN;
          w_ret_mul_nxt = 1'b0;
        end else begin
          w_ctl = PIPE_FREEZE;
          if (r_mem_cnt != {MEM_CW{1'b1}}) begin
            w_mem_cnt_nxt = r_mem_cnt + c_mem_one;
          end
        end
      end

      default: begin
        w_ctl       = PIPE_CLEAR;
        w_state_nxt = INIT;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  assign bus.pc_en       = w_ctl.pc_en;
  assign bus.ifid_en     = w_ctl.ifid_en;
  assign bus.idex_en     = w_ctl.idex_en;
  assign bus.exmem_en    = w_ctl.exmem_en;
  assign bus.memwb_en    = w_ctl.memwb_en;
  assign bus.ifid_flush  = w_ctl.ifid_flush;
  assign bus.idex_flush  = w_ctl.idex_flush;
  assign bus.exmem_flush = w_ctl.exmem_flush;
  assign bus.mem_err     = w_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_pipe_ctrl
// Description : Self-checking bench for cpu_pipe_ctrl (MUL_LAT=4,
//               MEM_TIMEOUT=8). A cycle-level behavioural model tracks the
//               pipeline situation (clearing, multiply cycles left, memory
//               wait length) and is compared with the DUT every cycle; directed
//               vectors add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pipe_ctrl;

  localparam int REG_AW      = 5;
  localparam int MUL_LAT     = 4;
  localparam int MEM_TIMEOUT = 8;

  // Observed/expected word: {pc, ifid, idex, exmem, memwb, fIF, fID, fEX, err}
  localparam logic [8:0] E_CLEAR  = 9'b0_1111_111_0;
  localparam logic [8:0] E_RUN    = 9'b1_1111_000_0;
  localparam logic [8:0] E_FREEZE = 9'b0_0000_000_0;
  localparam logic [8:0] E_BRANCH = 9'b1_1111_110_0;
  localparam logic [8:0] E_MUL    = 9'b0_0011_001_0;
  localparam logic [8:0] E_LDUSE  = 9'b0_0111_010_0;
  localparam logic [8:0] E_TMO    = 9'b1_1111_001_1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_pipe_ctrl_if #(.REG_AW(REG_AW)) bus ();

  cpu_pipe_ctrl #(
    .REG_AW      (REG_AW),
    .MUL_LAT     (MUL_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mem_err};
  endfunction

  // ------------------------------------------------------------------ model
  bit m_clearing   = 1'b1;   // first cycle out of reset
  int m_mul_left   = 0;      // multiply stall cycles still owed after this one
  bit m_mem_wait   = 1'b0;   // an unacknowledged access is outstanding
  int m_wait_cyc   = 0;      // cycles spent waiting so far

  function automatic logic [8:0] model_expect();
    logic ld_use;
    ld_use = bus.ex_is_load && (bus.ex_rd != 0) &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    if (!rst_n || m_clearing)                  return E_CLEAR;
    if (m_mem_wait) begin
      if (bus.mem_ack)                         return (m_mul_left > 0) ? E_MUL : E_RUN;
      if (m_wait_cyc == MEM_TIMEOUT - 1)       return E_TMO;
      return E_FREEZE;
    end
    if (bus.mem_req && !bus.mem_ack)           return E_FREEZE;
    if (m_mul_left > 0)                        return E_MUL;
    if (bus.ex_br_taken)                       return E_BRANCH;
    if (bus.ex_mul_start)                      return E_MUL;
    if (ld_use)                                return E_LDUSE;
    return E_RUN;
  endfunction

  // Advance the model to what the next rising edge will produce; inputs are
  // only changed just after rising edges, so they are already final here.
  task automatic model_advance();
    if (!rst_n) begin
      m_clearing = 1'b1; m_mul_left = 0; m_mem_wait = 1'b0; m_wait_cyc = 0;
    end else if (m_clearing) begin
      m_clearing = 1'b0;
    end else if (m_mem_wait) begin
      if (bus.mem_ack) begin
        m_mem_wait = 1'b0;
        if (m_mul_left > 0) m_mul_left--;
      end else if (m_wait_cyc == MEM_TIMEOUT - 1) begin
        m_mem_wait = 1'b0;
        m_mul_left = 0;
      end else begin
        m_wait_cyc++;
      end
    end else if (bus.mem_req && !bus.mem_ack) begin
      m_mem_wait = 1'b1;
      m_wait_cyc = 0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
    end else if (!bus.ex_br_taken && bus.ex_mul_start) begin
      m_mul_left = MUL_LAT - 2;
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    logic [8:0] exp_v;
    logic [8:0] got_v;
    exp_v = model_expect();
    got_v = observed();
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got=%b exp=%b", $time, got_v, exp_v);
    end
    model_advance();
  end

  // ------------------------------------------------------------- stimulus
  task automatic lit_now(input string name, input logic [8:0] exp_v);
    logic [8:0] got_v;
    got_v = observed();
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got_v, exp_v);
    end
  endtask

  task automatic lit(input string name, input logic [8:0] exp_v);
    @(negedge clk);
    lit_now(name, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_is_load = 1'b0; bus.ex_rd = '0; bus.ex_br_taken = 1'b0;
    bus.ex_mul_start = 1'b0; bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    lit("reset_held", E_CLEAR);
    tick();
    rst_n = 1'b1;

    // 1: INIT cycle then RUN
    lit("t1_init_cycle", E_CLEAR);
    tick(); lit("t1_run", E_RUN);

    // 2: load-use via rs2, then x0 destination, then rs1 and unused-rs1
    tick();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    lit("t2_ldu_rs2", E_LDUSE);
    tick(); bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
    lit("t2_rd_zero", E_RUN);
    tick(); idle_inputs();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
    lit("t2_ldu_rs1", E_LDUSE);
    tick(); bus.id_use_rs1 = 1'b0;
    lit("t2_rs1_unused", E_RUN);

    // 3: branch with concurrent load-use; branch also wins over same-cycle ack'd access
    tick(); bus.id_use_rs1 = 1'b1; bus.ex_br_taken = 1'b1;
    lit("t3_br_over_ldu", E_BRANCH);
    tick(); idle_inputs(); bus.ex_br_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
    lit("t3_br_with_ack", E_BRANCH);

    // 4: multiply, MUL_LAT=4 -> three stall cycles, branch ignored mid-multiply
    tick(); idle_inputs(); bus.ex_mul_start = 1'b1;
    lit("t4_mul_c1", E_MUL);
    tick(); bus.ex_mul_start = 1'b0; bus.ex_br_taken = 1'b1;
    lit("t4_mul_c2", E_MUL);
    tick(); bus.ex_br_taken = 1'b0;
    lit("t4_mul_c3", E_MUL);
    tick(); lit("t4_mul_done", E_RUN);

    // 5: access acknowledged on its 3rd cycle
    tick(); bus.mem_req = 1'b1;
    lit("t5_freeze1", E_FREEZE);
    tick(); lit("t5_freeze2", E_FREEZE);
    tick(); bus.mem_ack = 1'b1;
    lit("t5_ack", E_RUN);
    tick(); idle_inputs(); lit("t5_after", E_RUN);

    // Multiply interrupted by a memory wait resumes the multiply afterwards
    tick(); bus.ex_mul_start = 1'b1;
    lit("mm_start", E_MUL);
    tick(); bus.ex_mul_start = 1'b0; bus.mem_req = 1'b1;
    lit("mm_freeze1", E_FREEZE);
    tick(); lit("mm_freeze2", E_FREEZE);
    tick(); bus.mem_ack = 1'b1;
    lit("mm_ack", E_MUL);
    tick(); idle_inputs(); lit("mm_last", E_MUL);
    tick(); lit("mm_done", E_RUN);

    // 6: no ack, timeout on the 8th cycle spent waiting
    tick(); bus.mem_req = 1'b1;
    lit("t6_req", E_FREEZE);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
      tick(); lit("t6_wait", E_FREEZE);
    end
    tick(); lit("t6_timeout", E_TMO);
    tick(); bus.mem_req = 1'b0;
    lit("t6_resume", E_RUN);

    // Reset mid-wait returns to INIT immediately, pending wait discarded
    tick(); bus.mem_req = 1'b1;
    lit("t6r_req", E_FREEZE);
    tick(); lit("t6r_wait", E_FREEZE);
    tick(); rst_n = 1'b0;
    #1 lit_now("t6r_async_init", E_CLEAR);
    bus.mem_req = 1'b0;
    tick(); rst_n = 1'b1;
    lit("t6r_init_cycle", E_CLEAR);
    tick(); lit("t6r_run", E_RUN);
    tick(); lit("t6r_run2", E_RUN);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t stimulus did not complete", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
